// File: rtl/crack_sched.sv
// Purpose: spreads candidate keys [key_lo, key_hi] over NUM_CORES crack cores and reports the smallest matching key.
// Latency: accepted start to first core_en is 2 cycles; last verdict to rdy=1 is 2 cycles.
// Backpressure: a core gets a key only while it reports core_rdy and has no verdict outstanding; en is ignored while rdy=0.
module crack_sched #(
  parameter int NUM_CORES = 2,
  parameter int KEY_W     = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  output logic                       rdy,
  input  logic [KEY_W-1:0]           key_lo,
  input  logic [KEY_W-1:0]           key_hi,
  output logic [KEY_W-1:0]           key,
  output logic                       key_valid,
  output logic [NUM_CORES-1:0]       core_en,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  input  logic [NUM_CORES-1:0]       core_rdy,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_match
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                     r_state;
  logic                       r_rdy;
  logic [KEY_W-1:0]           r_key;
  logic                       r_key_valid;
  logic [NUM_CORES-1:0]       r_core_en;
  // Doubles as the in-flight key record: a core's slot only changes on its next dispatch.
  logic [NUM_CORES*KEY_W-1:0] r_core_key;
  logic [KEY_W-1:0]           r_key_hi;
  // One bit wider than a key so that key_hi = all-ones still ends the sweep instead of wrapping.
  logic [KEY_W:0]             r_next_key;
  logic [NUM_CORES-1:0]       r_busy;
  logic [KEY_W-1:0]           r_best;
  logic                       r_found;

  logic [KEY_W-1:0]           w_best;
  logic                       w_found;
  logic [NUM_CORES-1:0]       w_avail;
  logic [NUM_CORES-1:0]       w_grant;
  logic [NUM_CORES-1:0]       w_busy_left;
  logic                       w_in_range;
  logic                       w_dispatch;

  assign rdy       = r_rdy;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign core_en   = r_core_en;
  assign core_key  = r_core_key;

  // Verdicts only count for cores we are waiting on; stale pulses after a reset fall out here.
  assign w_busy_left = r_busy & ~core_done;

  // A core is a dispatch candidate when it is idle and owes us no verdict; pick the lowest index.
  assign w_avail    = core_rdy & ~r_busy;
  assign w_grant    = w_avail & (~w_avail + NUM_CORES'(1'b1));
  assign w_in_range = (r_next_key <= {1'b0, r_key_hi});
  assign w_dispatch = (r_state == S_SEARCH) && !r_found && w_in_range && (w_avail != '0);

  // Fold every matching verdict of this cycle into the running minimum.
  always_comb begin
    w_best  = r_best;
    w_found = r_found;
    for (int i = 0; i < NUM_CORES; i++) begin
      if ((r_state != S_IDLE) && core_done[i] && r_busy[i] && core_match[i]) begin
        if (!w_found || (r_core_key[i*KEY_W +: KEY_W] < w_best)) begin
          w_best  = r_core_key[i*KEY_W +: KEY_W];
          w_found = 1'b1;
        end
      end
    end
  end

  // Search control: start handshake, ascending dispatch, drain of in-flight cores, result publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rdy       <= 1'b1;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_core_en   <= '0;
      r_core_key  <= '0;
      r_key_hi    <= '0;
      r_next_key  <= '0;
      r_busy      <= '0;
      r_best      <= '0;
      r_found     <= 1'b0;
    end else begin
      r_core_en <= '0;
      r_busy    <= w_busy_left;
      r_best    <= w_best;
      r_found   <= w_found;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_key_hi    <= key_hi;
            r_next_key  <= {1'b0, key_lo};
            r_best      <= '0;
            r_found     <= 1'b0;
            r_key_valid <= 1'b0;
            r_rdy       <= 1'b0;
            r_state     <= (key_lo > key_hi) ? S_DONE : S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (w_dispatch) begin
            r_core_en  <= w_grant;
            r_busy     <= w_busy_left | w_grant;
            r_next_key <= r_next_key + (KEY_W+1)'(1);
            for (int i = 0; i < NUM_CORES; i++) begin
              if (w_grant[i]) begin
                r_core_key[i*KEY_W +: KEY_W] <= r_next_key[KEY_W-1:0];
              end
            end
          end
          // Once a match is known no higher key can win, so stop handing out work.
          if (r_found || !w_in_range) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Every key below the first match is done or in flight; wait for all of them.
          if (w_busy_left == '0) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (r_found) begin
            r_key <= r_best;
          end
          r_key_valid <= r_found;
          r_rdy       <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crack_sched.sv
module tb_crack_sched;

  localparam int NC = 2;
  localparam int KW = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             rdy;
  logic [KW-1:0]    key_lo;
  logic [KW-1:0]    key_hi;
  logic [KW-1:0]    key;
  logic             key_valid;
  logic [NC-1:0]    core_en;
  logic [NC*KW-1:0] core_key;
  logic [NC-1:0]    core_rdy;
  logic [NC-1:0]    core_done;
  logic [NC-1:0]    core_match;

  crack_sched #(.NUM_CORES(NC), .KEY_W(KW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .rdy        (rdy),
    .key_lo     (key_lo),
    .key_hi     (key_hi),
    .key        (key),
    .key_valid  (key_valid),
    .core_en    (core_en),
    .core_key   (core_key),
    .core_rdy   (core_rdy),
    .core_done  (core_done),
    .core_match (core_match)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Core model configuration and dispatch log.
  int          lat[NC];
  int          match_keys[$];
  int          dcount[int];
  int          ndisp;
  int          maxkey;
  bit          saw_zero;
  bit          saw_simul;
  int          overrun = 0;
  time         last_done_t;
  time         rdy_t;
  logic        mbusy[NC];
  int          cnt[NC];
  logic [KW-1:0] mkey[NC];

  typedef struct packed {
    logic          vld;
    logic [KW-1:0] key;
  } exp_t;
  exp_t          exp_q[$];
  logic [KW-1:0] last_key;

  function automatic bit is_match(input logic [KW-1:0] k);
    foreach (match_keys[j]) if (match_keys[j] == int'(k)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    dcount.delete();
    ndisp    = 0;
    maxkey   = -1;
    saw_zero = 1'b0;
  endtask

  // Starts one search, waits (bounded) for rdy, then checks the scoreboard entry.
  task automatic run_search(input logic [KW-1:0] lo, input logic [KW-1:0] hi,
                            input logic exp_vld, input logic [KW-1:0] exp_key,
                            output int first_disp, output int total_cyc);
    exp_t e;
    exp_t got;
    bit   done;
    int   cyc;
    e.vld    = exp_vld;
    e.key    = exp_vld ? exp_key : last_key;
    last_key = e.key;
    exp_q.push_back(e);
    clear_log();
    key_lo     = lo;
    key_hi     = hi;
    en         = 1'b1;
    first_disp = -1;
    cyc        = 0;
    done       = 1'b0;
    while (!done && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      en = 1'b0;
      if (first_disp < 0 && core_en != '0) first_disp = cyc;
      if (rdy) done = 1'b1;
    end
    total_cyc = cyc;
    rdy_t     = $time;
    chk("search_completes", done, 1);
    got = exp_q.pop_front();
    chk("result_key_valid", key_valid, got.vld);
    chk("result_key", key, got.key);
  endtask

  // Crack-core array model: fixed per-core latency, match on a configurable key set.
  initial begin
    int nd;
    core_rdy   = '1;
    core_done  = '0;
    core_match = '0;
    for (int i = 0; i < NC; i++) begin
      mbusy[i] = 1'b0;
      cnt[i]   = 0;
      mkey[i]  = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      nd = 0;
      for (int i = 0; i < NC; i++) begin
        core_done[i]  = 1'b0;
        core_match[i] = 1'b0;
        if (mbusy[i]) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            core_done[i]  = 1'b1;
            core_match[i] = is_match(mkey[i]);
            mbusy[i]      = 1'b0;
            nd++;
            last_done_t   = $time;
          end
        end
        if (core_en[i]) begin
          if (mbusy[i]) overrun++;
          mbusy[i] = 1'b1;
          cnt[i]   = lat[i];
          mkey[i]  = core_key[i*KW +: KW];
          ndisp++;
          if (dcount.exists(int'(mkey[i]))) dcount[int'(mkey[i])]++;
          else dcount[int'(mkey[i])] = 1;
          if (int'(mkey[i]) > maxkey) maxkey = int'(mkey[i]);
          if (mkey[i] == '0) saw_zero = 1'b1;
        end
        core_rdy[i] = !mbusy[i];
      end
      if (nd > 1) saw_simul = 1'b1;
    end
  end

  initial begin
    int fd;
    int tc;
    int nbad;
    rst_n     = 1'b0;
    en        = 1'b0;
    key_lo    = '0;
    key_hi    = '0;
    lat[0]    = 10;
    lat[1]    = 10;
    last_key  = '0;
    saw_simul = 1'b0;
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", rdy, 1);
    chk("reset_key", key, 0);
    chk("reset_key_valid", key_valid, 0);
    chk("reset_core_en", core_en, 0);
    chk("reset_core_key", core_key, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single match at 0x18 with two latency-10 cores.
    match_keys.delete();
    match_keys.push_back(32'h18);
    run_search(24'h00, 24'hFF, 1'b1, 24'h000018, fd, tc);
    chk("single_first_dispatch_cycle", fd, 2);
    chk("single_no_key_above_0x19", (maxkey <= 32'h19), 1);
    nbad = 0;
    for (int k = 0; k <= 32'h18; k++) if (!dcount.exists(k) || dcount[k] != 1) nbad++;
    chk("single_each_key_once", nbad, 0);

    // Higher match answers 5 cycles before the lower one.
    match_keys.delete();
    match_keys.push_back(32'h20);
    match_keys.push_back(32'h21);
    lat[0] = 10;
    lat[1] = 4;
    run_search(24'h20, 24'h2F, 1'b1, 24'h000020, fd, tc);

    // Exhaustive sweep with no match.
    match_keys.delete();
    lat[0] = 3;
    lat[1] = 5;
    run_search(24'h10, 24'h1F, 1'b0, 24'h0, fd, tc);
    chk("exh_dispatch_count", ndisp, 16);
    nbad = 0;
    for (int k = 32'h10; k <= 32'h1F; k++) if (!dcount.exists(k) || dcount[k] != 1) nbad++;
    chk("exh_keys_distinct", nbad, 0);
    chk("exh_first_dispatch_cycle", fd, 2);
    chk("exh_verdict_to_rdy", rdy_t - last_done_t, 20);

    // Empty range.
    run_search(24'h05, 24'h04, 1'b0, 24'h0, fd, tc);
    chk("empty_dispatch_count", ndisp, 0);
    chk("empty_rdy_within_3", (tc <= 3), 1);

    // Top of key space, both verdicts land in the same cycle.
    lat[0]    = 5;
    lat[1]    = 4;
    saw_simul = 1'b0;
    run_search(24'hFFFFFE, 24'hFFFFFF, 1'b0, 24'h0, fd, tc);
    chk("top_dispatch_count", ndisp, 2);
    chk("top_no_wrap_to_zero", saw_zero, 0);
    chk("top_simultaneous_done", saw_simul, 1);

    match_keys.push_back(32'hFFFFFE);
    match_keys.push_back(32'hFFFFFF);
    saw_simul = 1'b0;
    run_search(24'hFFFFFE, 24'hFFFFFF, 1'b1, 24'hFFFFFE, fd, tc);
    chk("top_match_simultaneous_done", saw_simul, 1);

    // Asynchronous reset in the middle of a search.
    match_keys.delete();
    lat[0] = 30;
    lat[1] = 30;
    key_lo = 24'h00;
    key_hi = 24'hFF;
    en     = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_rdy", rdy, 1);
    chk("midreset_key_valid", key_valid, 0);
    chk("midreset_core_en", core_en, 0);
    chk("midreset_key", key, 0);
    last_key = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stale cores still hold matching keys 0 and 1; their verdicts must be ignored.
    match_keys.push_back(32'h00);
    match_keys.push_back(32'h01);
    match_keys.push_back(32'h31);
    lat[0] = 4;
    lat[1] = 4;
    run_search(24'h30, 24'h3F, 1'b1, 24'h000031, fd, tc);
    chk("post_reset_no_key0_dispatch", saw_zero, 0);
    chk("core_never_overrun", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
